// File: rtl/adc_sampler_pkg.sv
// rtl/adc_sampler_pkg.sv - shared types and widths for the joystick ADC sampler
package adc_sampler_pkg;

  localparam int unsigned ADC_CH_W   = 5;
  localparam int unsigned ADC_DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT_RSP,
    PUBLISH
  } state_e;

  typedef enum logic {
    AXIS_X,
    AXIS_Y
  } axis_e;

endpackage

// File: rtl/adc_joystick_sampler_if.sv
// rtl/adc_joystick_sampler_if.sv - ADC core command/response streams
interface adc_joystick_sampler_if;

  logic                                         command_valid;
  logic [adc_sampler_pkg::ADC_CH_W-1:0]         command_channel;
  logic                                         command_startofpacket;
  logic                                         command_endofpacket;
  logic                                         command_ready;

  logic                                         response_valid;
  logic [adc_sampler_pkg::ADC_CH_W-1:0]         response_channel;
  logic [adc_sampler_pkg::ADC_DATA_W-1:0]       response_data;
  logic                                         response_startofpacket;
  logic                                         response_endofpacket;

  // Sampler side: issues commands, consumes responses
  modport master (
    output command_valid, command_channel, command_startofpacket, command_endofpacket,
    input  command_ready,
    input  response_valid, response_channel, response_data,
    input  response_startofpacket, response_endofpacket
  );

  // ADC core side
  modport slave (
    input  command_valid, command_channel, command_startofpacket, command_endofpacket,
    output command_ready,
    output response_valid, response_channel, response_data,
    output response_startofpacket, response_endofpacket
  );

endinterface

// File: rtl/adc_avg_accum.sv
// rtl/adc_avg_accum.sv - per-axis sample accumulator sized so it never overflows
module adc_avg_accum
  import adc_sampler_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           add,
  input  logic                           clear,
  input  logic [ADC_DATA_W-1:0]          data,
  output logic [ADC_DATA_W+AVG_LOG2-1:0] acc
);

  localparam int unsigned ACC_W = ADC_DATA_W + AVG_LOG2;

  logic [ACC_W-1:0] acc_q, acc_d;

  // Clear has priority over add; the two are never requested together
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = acc_q + ACC_W'(data);
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/adc_joystick_sampler.sv
// rtl/adc_joystick_sampler.sv - alternating X/Y ADC sequencer with per-axis averaging
module adc_joystick_sampler
  import adc_sampler_pkg::*;
#(
  parameter int unsigned CH_X        = 1,
  parameter int unsigned CH_Y        = 2,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                   clock_clk,
  input  logic                   reset_sink_reset_n,
  input  logic                   enable,
  input  logic                   clear_err,
  adc_joystick_sampler_if.master adc,
  output logic [ADC_DATA_W-1:0]  x_value,
  output logic [ADC_DATA_W-1:0]  y_value,
  output logic                   sample_strobe,
  output logic                   err_mismatch,
  output logic                   err_timeout
);

  localparam int unsigned ACC_W  = ADC_DATA_W + AVG_LOG2;
  localparam int unsigned PAIR_W = AVG_LOG2 + 1;
  localparam int unsigned TMO_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [ADC_CH_W-1:0] CH_X_L   = ADC_CH_W'(CH_X);
  localparam logic [ADC_CH_W-1:0] CH_Y_L   = ADC_CH_W'(CH_Y);
  localparam logic [PAIR_W-1:0]   PAIRS    = PAIR_W'(1 << AVG_LOG2);
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e                  state_q, state_d;
  axis_e                   axis_q, axis_d;
  logic [PAIR_W-1:0]       pair_q, pair_d, pair_inc;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [ADC_DATA_W-1:0]   x_hold_q, x_hold_d, y_hold_q, y_hold_d;
  logic                    err_mm_q, err_mm_d, err_to_q, err_to_d;
  logic                    add_x, add_y, clear_acc, set_mismatch, set_timeout;
  logic [ADC_CH_W-1:0]     exp_ch;
  logic                    rsp_match;
  logic [ACC_W-1:0]        acc_x, acc_y;
  logic [ADC_DATA_W-1:0]   x_mean, y_mean;
  logic                    unused_rsp_framing;

  adc_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_acc_x (
    .clk(clock_clk), .rst_n(reset_sink_reset_n),
    .add(add_x), .clear(clear_acc), .data(adc.response_data), .acc(acc_x)
  );

  adc_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_acc_y (
    .clk(clock_clk), .rst_n(reset_sink_reset_n),
    .add(add_y), .clear(clear_acc), .data(adc.response_data), .acc(acc_y)
  );

  assign exp_ch    = (axis_q == AXIS_X) ? CH_X_L : CH_Y_L;
  assign rsp_match = adc.response_valid && (adc.response_channel == exp_ch);
  assign pair_inc  = pair_q + PAIR_W'(1);
  assign x_mean    = ADC_DATA_W'(acc_x >> AVG_LOG2);
  assign y_mean    = ADC_DATA_W'(acc_y >> AVG_LOG2);

  // Next-state, datapath control and sticky error flags
  always_comb begin
    state_d      = state_q;
    axis_d       = axis_q;
    pair_d       = pair_q;
    tmo_d        = tmo_q;
    add_x        = 1'b0;
    add_y        = 1'b0;
    clear_acc    = 1'b0;
    set_mismatch = 1'b0;
    set_timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        clear_acc = 1'b1;
        pair_d    = '0;
        axis_d    = AXIS_X;
        if (enable) state_d = CMD;
      end
      CMD: begin
        // An accepted command always completes, even if enable just dropped
        if (adc.command_ready) begin
          state_d = WAIT_RSP;
          tmo_d   = '0;
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      WAIT_RSP: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (rsp_match) begin
          if (axis_q == AXIS_X) begin
            add_x   = 1'b1;
            axis_d  = AXIS_Y;
            state_d = enable ? CMD : IDLE;
          end else begin
            add_y  = 1'b1;
            pair_d = pair_inc;
            if (pair_inc == PAIRS) begin
              state_d = enable ? PUBLISH : IDLE;
            end else begin
              axis_d  = AXIS_X;
              state_d = enable ? CMD : IDLE;
            end
          end
        end else begin
          set_mismatch = adc.response_valid;
          // Retry the same axis; nothing was accumulated for it
          if (tmo_q == TMO_LAST) begin
            set_timeout = 1'b1;
            state_d     = enable ? CMD : IDLE;
          end
        end
      end
      PUBLISH: begin
        clear_acc = 1'b1;
        pair_d    = '0;
        axis_d    = AXIS_X;
        state_d   = enable ? CMD : IDLE;
      end
      default: state_d = IDLE;
    endcase

    x_hold_d = (state_q == PUBLISH) ? x_mean : x_hold_q;
    y_hold_d = (state_q == PUBLISH) ? y_mean : y_hold_q;
    err_mm_d = set_mismatch ? 1'b1 : (clear_err ? 1'b0 : err_mm_q);
    err_to_d = set_timeout  ? 1'b1 : (clear_err ? 1'b0 : err_to_q);
  end

  // State and holding registers
  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state_q  <= IDLE;
      axis_q   <= AXIS_X;
      pair_q   <= '0;
      tmo_q    <= '0;
      x_hold_q <= '0;
      y_hold_q <= '0;
      err_mm_q <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      axis_q   <= axis_d;
      pair_q   <= pair_d;
      tmo_q    <= tmo_d;
      x_hold_q <= x_hold_d;
      y_hold_q <= y_hold_d;
      err_mm_q <= err_mm_d;
      err_to_q <= err_to_d;
    end
  end

  // The fresh mean is visible in the same cycle as the strobe
  assign x_value       = (state_q == PUBLISH) ? x_mean : x_hold_q;
  assign y_value       = (state_q == PUBLISH) ? y_mean : y_hold_q;
  assign sample_strobe = (state_q == PUBLISH);
  assign err_mismatch  = err_mm_q;
  assign err_timeout   = err_to_q;

  assign adc.command_valid         = (state_q == CMD);
  assign adc.command_channel       = (state_q == CMD) ? exp_ch : '0;
  assign adc.command_startofpacket = adc.command_valid;
  assign adc.command_endofpacket   = adc.command_valid;

  // Responses are single-beat, so packet framing carries no information
  assign unused_rsp_framing = adc.response_startofpacket ^ adc.response_endofpacket;

endmodule

// File: tb/tb_adc_joystick_sampler.sv
// tb/tb_adc_joystick_sampler.sv - self-checking bench for adc_joystick_sampler
module tb_adc_joystick_sampler;

  localparam int N_AVG = 4;
  localparam logic [4:0] CHX = 5'd1;
  localparam logic [4:0] CHY = 5'd2;

  logic        clk = 1'b0;
  logic        rst_n, enable, clear_err;
  logic [11:0] x_value, y_value;
  logic        sample_strobe, err_mismatch, err_timeout;
  int          tests_run = 0, tests_failed = 0;
  int          strobe_cnt = 0;
  logic [11:0] last_x = '0, last_y = '0;

  adc_joystick_sampler_if ifc ();

  adc_joystick_sampler dut (
    .clock_clk(clk), .reset_sink_reset_n(rst_n), .enable(enable), .clear_err(clear_err),
    .adc(ifc.master), .x_value(x_value), .y_value(y_value), .sample_strobe(sample_strobe),
    .err_mismatch(err_mismatch), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sample_strobe) begin
      strobe_cnt = strobe_cnt + 1;
      last_x = x_value;
      last_y = y_value;
    end
  end

  function automatic logic [11:0] mean_of(input logic [11:0] v [N_AVG]);
    int s = 0;
    foreach (v[i]) s += int'(v[i]);
    return 12'(s / N_AVG);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; clear_err = 1'b0;
    ifc.command_ready = 1'b0; ifc.response_valid = 1'b0;
    ifc.response_channel = '0; ifc.response_data = '0;
    ifc.response_startofpacket = 1'b0; ifc.response_endofpacket = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_cmd(output logic [4:0] ch, output bit ok);
    ok = 1'b0; ch = '0;
    for (int i = 0; i < 2000; i++) begin
      if (ifc.command_valid) begin
        ch = ifc.command_channel; ok = 1'b1; return;
      end
      tick();
    end
  endtask

  // ADC model: accept after random backpressure, echo the commanded channel
  task automatic answer_cmd(input logic [11:0] data, output logic [4:0] ch, output bit ok);
    wait_cmd(ch, ok);
    if (!ok) return;
    repeat ($urandom_range(0, 2)) tick();
    ifc.command_ready = 1'b1; tick(); ifc.command_ready = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
    ifc.response_valid = 1'b1; ifc.response_channel = ch; ifc.response_data = data;
    tick();
    ifc.response_valid = 1'b0;
  endtask

  task automatic run_batch(input logic [11:0] xs [N_AVG], input logic [11:0] ys [N_AVG],
                           input int first, output logic [4:0] chs [2*N_AVG],
                           output bit ok, output int early);
    bit o;
    int s0 = strobe_cnt;
    ok = 1'b1; early = 0;
    foreach (chs[i]) chs[i] = '0;
    for (int i = first; i < 2*N_AVG; i++) begin
      if (i == 2*N_AVG-1) early = strobe_cnt - s0;
      answer_cmd((i % 2) ? ys[i/2] : xs[i/2], chs[i], o);
      if (!o) ok = 1'b0;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0; tick();
    if ({x_value, y_value, sample_strobe, err_mismatch, err_timeout, ifc.command_valid} !== '0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h expected 0",
        {x_value, y_value, sample_strobe, err_mismatch, err_timeout, ifc.command_valid});
    end
    tests_run++;
    rst_n = 1'b1; tick();
    ifc.response_valid = 1'b1; ifc.response_channel = 5'd9; tick(); ifc.response_valid = 1'b0;
    tick();
    tests_run++;
    if (err_mismatch !== 1'b0) begin
      tests_failed++; $display("FAIL idle_rsp_ignored: err_mismatch=%0d expected 0", err_mismatch);
    end
    enable = 1'b1; #1;
    tests_run++;
    if (ifc.command_valid !== 1'b0) begin
      tests_failed++; $display("FAIL cmd_not_early: command_valid=%0d expected 0", ifc.command_valid);
    end
    tick();
    tests_run++;
    if (ifc.command_valid !== 1'b1 || ifc.command_channel !== CHX) begin
      tests_failed++; $display("FAIL cmd_rise: valid=%0d ch=%0d expected 1/%0d",
        ifc.command_valid, ifc.command_channel, CHX);
    end
  endtask

  task automatic test_average();
    logic [11:0] xs [N_AVG], ys [N_AVG];
    logic [4:0] chs [2*N_AVG];
    bit ok; int early, s0;
    for (int b = 0; b < 4; b++) begin
      do_reset(); enable = 1'b1;
      foreach (xs[i]) begin xs[i] = 12'($urandom_range(0, 4095)); ys[i] = 12'($urandom_range(0, 4095)); end
      if (b == 0) begin xs = '{100, 200, 300, 400}; ys = '{4000, 4000, 4000, 4000}; end
      if (b == 3) begin xs = '{4095, 4095, 4095, 4095}; ys = '{4095, 4095, 4095, 4095}; end
      s0 = strobe_cnt;
      run_batch(xs, ys, 0, chs, ok, early);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL avg_cmd_timeout: batch %0d no command", b); end
      for (int i = 0; i < 2*N_AVG; i++) begin
        tests_run++;
        if (chs[i] !== ((i % 2) ? CHY : CHX)) begin
          tests_failed++; $display("FAIL avg_channel: batch %0d cmd %0d ch=%0d expected %0d",
            b, i, chs[i], (i % 2) ? CHY : CHX);
        end
      end
      tests_run++;
      if (early !== 0 || strobe_cnt - s0 !== 1) begin
        tests_failed++; $display("FAIL avg_strobe_count: early=%0d total=%0d expected 0/1", early, strobe_cnt - s0);
      end
      tests_run++;
      if (last_x !== mean_of(xs) || last_y !== mean_of(ys)) begin
        tests_failed++; $display("FAIL avg_value: x=%0d y=%0d expected %0d/%0d", last_x, last_y, mean_of(xs), mean_of(ys));
      end
      tests_run++;
      if (x_value !== mean_of(xs) || y_value !== mean_of(ys)) begin
        tests_failed++; $display("FAIL avg_hold: x=%0d y=%0d expected %0d/%0d", x_value, y_value, mean_of(xs), mean_of(ys));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] ch; bit ok; int bad = 0;
    do_reset(); enable = 1'b1;
    wait_cmd(ch, ok);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifc.command_valid !== 1'b1 || ifc.command_channel !== CHX) bad++;
    end
    tests_run++;
    if (!ok || bad != 0) begin
      tests_failed++; $display("FAIL backpressure_hold: bad cycles=%0d ok=%0d expected 0/1", bad, ok);
    end
    ifc.command_ready = 1'b1; tick(); ifc.command_ready = 1'b0;
    tests_run++;
    if (ifc.command_valid !== 1'b0) begin
      tests_failed++; $display("FAIL backpressure_accept: command_valid=%0d expected 0", ifc.command_valid);
    end
  endtask

  task automatic test_mismatch();
    logic [11:0] xs [N_AVG], ys [N_AVG];
    logic [4:0] chs [2*N_AVG];
    logic [4:0] ch; bit ok; int early, s0;
    do_reset(); enable = 1'b1;
    foreach (xs[i]) begin xs[i] = 12'($urandom_range(0, 4095)); ys[i] = 12'($urandom_range(0, 4095)); end
    xs[0] = 12'd512;
    s0 = strobe_cnt;
    wait_cmd(ch, ok);
    tests_run++;
    if (!ok || ch !== CHX) begin tests_failed++; $display("FAIL mm_first_cmd: ch=%0d expected %0d", ch, CHX); end
    ifc.command_ready = 1'b1; tick(); ifc.command_ready = 1'b0;
    ifc.response_valid = 1'b1; ifc.response_channel = 5'd3; ifc.response_data = 12'd999; tick();
    ifc.response_valid = 1'b0;
    tests_run++;
    if (err_mismatch !== 1'b1 || ifc.command_valid !== 1'b0) begin
      tests_failed++; $display("FAIL mm_flag: err=%0d cmd_valid=%0d expected 1/0", err_mismatch, ifc.command_valid);
    end
    ifc.response_valid = 1'b1; ifc.response_channel = CHY; ifc.response_data = 12'd77; clear_err = 1'b1; tick();
    ifc.response_valid = 1'b0; clear_err = 1'b0;
    tests_run++;
    if (err_mismatch !== 1'b1) begin
      tests_failed++; $display("FAIL mm_set_wins: err=%0d expected 1", err_mismatch);
    end
    ifc.response_valid = 1'b1; ifc.response_channel = CHX; ifc.response_data = 12'd512; tick();
    ifc.response_valid = 1'b0;
    run_batch(xs, ys, 1, chs, ok, early);
    tests_run++;
    if (!ok || strobe_cnt - s0 !== 1 || last_x !== mean_of(xs) || last_y !== mean_of(ys)) begin
      tests_failed++; $display("FAIL mm_average: strobes=%0d x=%0d y=%0d expected 1/%0d/%0d",
        strobe_cnt - s0, last_x, last_y, mean_of(xs), mean_of(ys));
    end
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    tests_run++;
    if (err_mismatch !== 1'b0 || err_timeout !== 1'b0) begin
      tests_failed++; $display("FAIL mm_clear: err_mismatch=%0d err_timeout=%0d expected 0/0", err_mismatch, err_timeout);
    end
  endtask

  task automatic test_timeout();
    logic [11:0] xs [N_AVG], ys [N_AVG];
    logic [4:0] chs [2*N_AVG];
    logic [4:0] ch; bit ok; int early, s0, n; logic pre;
    do_reset(); enable = 1'b1;
    foreach (xs[i]) begin xs[i] = 12'($urandom_range(0, 4095)); ys[i] = 12'($urandom_range(0, 4095)); end
    s0 = strobe_cnt;
    answer_cmd(xs[0], ch, ok);
    wait_cmd(ch, ok);
    tests_run++;
    if (!ok || ch !== CHY) begin tests_failed++; $display("FAIL to_y_cmd: ch=%0d expected %0d", ch, CHY); end
    ifc.command_ready = 1'b1; tick(); ifc.command_ready = 1'b0;
    n = 0; pre = 1'bx;
    while (!ifc.command_valid && n < 1100) begin
      tick(); n++;
      if (n == 1022) pre = err_timeout;
    end
    tests_run++;
    if (n != 1023 || pre !== 1'b0) begin
      tests_failed++; $display("FAIL to_latency: cycles=%0d pre_flag=%0d expected 1023/0", n, pre);
    end
    tests_run++;
    if (err_timeout !== 1'b1 || ifc.command_channel !== CHY) begin
      tests_failed++; $display("FAIL to_retry: err=%0d ch=%0d expected 1/%0d", err_timeout, ifc.command_channel, CHY);
    end
    run_batch(xs, ys, 1, chs, ok, early);
    tests_run++;
    if (!ok || strobe_cnt - s0 !== 1 || last_x !== mean_of(xs) || last_y !== mean_of(ys)) begin
      tests_failed++; $display("FAIL to_average: strobes=%0d x=%0d y=%0d expected 1/%0d/%0d",
        strobe_cnt - s0, last_x, last_y, mean_of(xs), mean_of(ys));
    end
  endtask

  task automatic test_disable();
    logic [11:0] xs [N_AVG], ys [N_AVG], xs2 [N_AVG], ys2 [N_AVG];
    logic [4:0] chs [2*N_AVG];
    logic [4:0] ch; bit ok; int early, s0, valid_seen;
    do_reset(); enable = 1'b1;
    foreach (xs[i]) begin
      xs[i] = 12'($urandom_range(0, 4095)); ys[i] = 12'($urandom_range(0, 4095));
      xs2[i] = 12'($urandom_range(0, 4095)); ys2[i] = 12'($urandom_range(0, 4095));
    end
    run_batch(xs, ys, 0, chs, ok, early);
    s0 = strobe_cnt;
    wait_cmd(ch, ok);
    ifc.command_ready = 1'b1; tick(); ifc.command_ready = 1'b0;
    enable = 1'b0; tick(); tick();
    ifc.response_valid = 1'b1; ifc.response_channel = CHX; ifc.response_data = 12'd4095; tick();
    ifc.response_valid = 1'b0;
    valid_seen = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (ifc.command_valid) valid_seen++; end
    tests_run++;
    if (valid_seen != 0 || strobe_cnt != s0) begin
      tests_failed++; $display("FAIL dis_idle: valid cycles=%0d strobes=%0d expected 0/0", valid_seen, strobe_cnt - s0);
    end
    tests_run++;
    if (x_value !== mean_of(xs) || y_value !== mean_of(ys)) begin
      tests_failed++; $display("FAIL dis_hold: x=%0d y=%0d expected %0d/%0d", x_value, y_value, mean_of(xs), mean_of(ys));
    end
    enable = 1'b1;
    wait_cmd(ch, ok);
    enable = 1'b0; tick();
    tests_run++;
    if (ifc.command_valid !== 1'b0) begin
      tests_failed++; $display("FAIL dis_cmd_drop: command_valid=%0d expected 0", ifc.command_valid);
    end
    enable = 1'b1;
    s0 = strobe_cnt;
    run_batch(xs2, ys2, 0, chs, ok, early);
    tests_run++;
    if (!ok || chs[0] !== CHX || strobe_cnt - s0 !== 1 || last_x !== mean_of(xs2) || last_y !== mean_of(ys2)) begin
      tests_failed++; $display("FAIL dis_restart: ch0=%0d strobes=%0d x=%0d y=%0d expected %0d/1/%0d/%0d",
        chs[0], strobe_cnt - s0, last_x, last_y, CHX, mean_of(xs2), mean_of(ys2));
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] xs [N_AVG], ys [N_AVG];
    logic [4:0] chs [2*N_AVG];
    logic [4:0] ch; bit ok; int early;
    do_reset(); enable = 1'b1;
    foreach (xs[i]) begin xs[i] = 12'($urandom_range(1000, 4095)); ys[i] = 12'($urandom_range(1000, 4095)); end
    run_batch(xs, ys, 0, chs, ok, early);
    wait_cmd(ch, ok);
    ifc.command_ready = 1'b1; tick(); ifc.command_ready = 1'b0;
    ifc.response_valid = 1'b1; ifc.response_channel = 5'd7; tick(); ifc.response_valid = 1'b0;
    tests_run++;
    if (err_mismatch !== 1'b1 || x_value !== mean_of(xs)) begin
      tests_failed++; $display("FAIL rst_mid_pre: err=%0d x=%0d expected 1/%0d", err_mismatch, x_value, mean_of(xs));
    end
    rst_n = 1'b0; #1;
    tests_run++;
    if ({x_value, y_value, sample_strobe, err_mismatch, err_timeout, ifc.command_valid} !== '0) begin
      tests_failed++; $display("FAIL rst_mid_outputs: got %h expected 0",
        {x_value, y_value, sample_strobe, err_mismatch, err_timeout, ifc.command_valid});
    end
    rst_n = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_average();
    test_backpressure();
    test_mismatch();
    test_timeout();
    test_disable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/adc_joystick_sampler.md
Name: adc_joystick_sampler

Overview:
Sequencer directly upstream/downstream of the modular ADC core. It issues single-beat conversion commands on the ADC command stream, alternating between the joystick X and Y channels. It consumes the matching ADC response stream, averages 2^AVG_LOG2 samples per axis, and publishes stable 12-bit X/Y values with an update strobe for the VGA game logic.

Parameters:
CH_X, 1, ADC channel number sampled for the X axis (5-bit).
CH_Y, 2, ADC channel number sampled for the Y axis (5-bit).
AVG_LOG2, 2, log2 of the number of samples averaged per axis (range 0..4).
TIMEOUT_CYC, 1023, number of cycles to wait for a response before retrying.

Ports:
clock_clk  in  1  system clock, same clock as the ADC core command/response interfaces
reset_sink_reset_n  in  1  asynchronous active-low reset
enable  in  1  run sampling while high
clear_err  in  1  single-cycle pulse that clears the sticky error flags
command_valid  out  1  command stream valid
command_channel  out  5  channel to convert
command_startofpacket  out  1  driven equal to command_valid
command_endofpacket  out  1  driven equal to command_valid
command_ready  in  1  command accepted by the ADC core
response_valid  in  1  response stream valid (no backpressure)
response_channel  in  5  channel of the returned sample
response_data  in  12  conversion result
response_startofpacket  in  1  ignored
response_endofpacket  in  1  ignored
x_value  out  12  averaged X result
y_value  out  12  averaged Y result
sample_strobe  out  1  one-cycle pulse when x_value/y_value update
err_mismatch  out  1  sticky: a response arrived with an unexpected channel
err_timeout  out  1  sticky: a response timed out

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs are 0; accumulators, sample counter and timeout counter are 0.
  - FSM state is IDLE; axis select = X.
- FSM states: IDLE, CMD, WAIT_RSP, PUBLISH.
- IDLE:
  - command_valid = 0.
  - If enable = 1, go to CMD on the next cycle with axis = X.
  - command_valid rises one cycle after enable is sampled high.
- CMD:
  - command_valid = 1; command_channel = CH_X or CH_Y per axis.
  - Channel is held stable until accepted.
  - When command_valid && command_ready in the same cycle, go to WAIT_RSP and clear the timeout counter.
- WAIT_RSP:
  - Timeout counter increments every cycle.
  - response_valid with response_channel equal to the expected channel: add response_data into that axis's accumulator (width 12+AVG_LOG2, cannot overflow).
    - If axis = X: toggle to Y, go to CMD.
    - If axis = Y: increment the pair counter. If it reaches 2^AVG_LOG2, go to PUBLISH; otherwise toggle to X and go to CMD.
  - response_valid with the wrong channel: discard the sample, set err_mismatch, remain in WAIT_RSP (counter keeps running).
  - Counter reaches TIMEOUT_CYC without a match: set err_timeout, go to CMD with the same axis. Nothing is accumulated.
- PUBLISH (one cycle):
  - x_value = acc_x >> AVG_LOG2; y_value = acc_y >> AVG_LOG2 (truncating).
  - sample_strobe = 1 for exactly this cycle.
  - Accumulators and pair counter clear; axis = X.
  - Next state is CMD if enable, else IDLE.
- x_value/y_value hold their last published value at all other times.
- enable deasserted:
  - In CMD: the command completes only if accepted in the current cycle. Otherwise drop command_valid and go to IDLE.
  - In WAIT_RSP: finish the outstanding transaction (match or timeout), then go to IDLE.
  - Entering IDLE clears accumulators, pair counter and axis; no strobe is produced.
- response_valid outside WAIT_RSP is ignored and sets no flag.
- clear_err clears both sticky flags. If a set event occurs in the same cycle, set wins.

Decomposition:
- Package adc_sampler_pkg:
  - state enum (IDLE, CMD, WAIT_RSP, PUBLISH).
  - ADC_CH_W = 5, ADC_DATA_W = 12.
  - Axis enum (AXIS_X, AXIS_Y).
- Sub-module adc_avg_accum, instantiated once per axis:
  - Inputs: add, clear, data.
  - Output: accumulator; the shifted mean is computed at PUBLISH.

Test Plan:
- AVG_LOG2=2, ADC model returns X = 100, 200, 300, 400 and Y = 4000 ×4 → exactly one sample_strobe after the 8th response; x_value = 250, y_value = 4000.
- Hold command_ready = 0 for 10 cycles while in CMD → command_valid stays 1 with command_channel = 1 throughout; the state does not advance.
- Answer an X command with response_channel = 3, then channel 1 data = 512 → err_mismatch = 1 and only 512 is accumulated. After clear_err, err_mismatch = 0.
- Never answer a Y command → after 1023 cycles err_timeout = 1 and a new command is issued with command_channel = 2.
- Deassert enable during WAIT_RSP, then deliver the response → FSM returns to IDLE, no strobe, outputs keep their old values.
- Assert reset mid-transaction → all outputs 0 immediately.
- All samples 4095 → x_value = y_value = 4095 (no accumulator overflow).
